lacc_mem_bridge: RTL
====================

// Module: lacc_mem_bridge
// PURPOSE
//  Downstream memory-side stage for the CNN accelerator data port. Accepts the
//  accelerator's word/half/byte load-store commands (valid/ready), queues them
//  and issues them in order to a simple SRAM-style request/response bus.
//  Returns read data (lane-aligned) as a push-only response stream, since the
//  accelerator cannot back-pressure responses. Also handles flush and error flags.
// PARAMETERS
//  REQ_DEPTH  4  command queue entries (power of 2, >=2)
//  MAX_OUTST  4  max issued-but-unanswered mem requests (power of 2, >=1)
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, asynchronous, active-high
//  lacc_flush       in   1   drop queued commands, discard in-flight responses
//  lacc_data_valid  in   1   command valid
//  lacc_data_ready  out  1   command accept (= queue not full, and not lacc_flush)
//  lacc_data_addr   in   32  byte address
//  lacc_data_read   in   1   1=load, 0=store
//  lacc_data_wdata  in   32  store data, LSB-justified
//  lacc_data_size   in   2   0=byte 1=half 2=word 3=illegal
//  lacc_drsp_valid  out  1   load data valid (one pulse per load, in order)
//  lacc_drsp_rdata  out  32  load data, LSB-justified, zero-extended
//  mem_req_valid    out  1   memory request valid
//  mem_req_ready    in   1   memory request accept
//  mem_req_addr     out  32  word address {addr[31:2],2'b00}
//  mem_req_we       out  1   1=write
//  mem_req_wstrb    out  4   byte lane enables (writes)
//  mem_req_wdata    out  32  lane-replicated write data
//  mem_rsp_valid    in   1   one response per issued request (read & write), in order
//  mem_rsp_rdata    in   32  read data (ignored for writes)
//  err              out  2   sticky: [0] misaligned/illegal cmd, [1] unexpected rsp
//  busy             out  1   queue non-empty | outstanding!=0 | lacc_drsp_valid
// BEHAVIOUR
//  Reset (async): queue empty, outstanding=0, discard=0, err=0.
//   mem_req_valid=0, lacc_drsp_valid=0, busy=0; lacc_data_ready=1 (queue empty).
//  Enqueue on lacc_data_valid&lacc_data_ready; ready depends only on full/flush.
//   A same-cycle dequeue does not free a slot for that cycle.
//  Issue: mem_req_valid = queue non-empty & outstanding<MAX_OUTST.
//   Head pops on mem_req_valid&mem_req_ready. Request fields are held stable
//   while valid & !ready. Each pop pushes tag {read, addr[1:0], size}.
//  outstanding: +1 on issue, -1 on mem_rsp_valid; both in one cycle = unchanged.
//  Store lanes: byte: wdata[7:0] x4, wstrb=4'b0001<<addr[1:0].
//   half: wdata[15:0] x2, wstrb=4'b0011<<addr[1:0]. word: wdata, wstrb=4'hF.
//  Misaligned (half & addr[0]; word & addr[1:0]!=0; size==3):
//   still issued, so response order is preserved. Store: wstrb=4'h0.
//   Load: returns data per the offset rule below. err[0] set on enqueue.
//  Load return: lacc_drsp_valid/rdata registered, 1 cycle after mem_rsp_valid
//   when popped tag is read & discard==0.
//   rdata = (mem_rsp_rdata >> 8*addr[1:0]) masked to 8/16/32 bits.
//   Size 3 returns a full word. Write responses are consumed silently.
//  Flush (1-cycle pulse, synchronous effect): queue cleared at the edge.
//   lacc_data_ready=0 in the flush cycle.
//   discard <= outstanding (minus 1 if mem_rsp_valid that cycle).
//   lacc_drsp_valid register cleared. Next mem_rsp_valid pulses decrement
//   discard and are dropped. New commands may issue immediately; in-order
//   memory responses keep them behind the discarded ones. A request stalled on
//   mem_req_ready at flush is withdrawn: mem_req_valid=0 next cycle.
//  mem_rsp_valid with outstanding==0: ignored, err[1] set, counters unchanged.
//  err bits clear only on rst.
// TESTING
//  Word store 0x1000 data 0xDEADBEEF, mem ready -> mem_req addr 0x1000 we=1
//   wstrb=F, wdata DEADBEEF; no lacc_drsp_valid.
//  Byte load 0x1003, mem rdata 0xAABBCCDD -> lacc_drsp_valid 1 cycle after
//   rsp, rdata 0x000000AA. Half load 0x1002 -> 0x0000AABB.
//  mem_req_ready=0 for 10 cycles, 6 commands -> 4 accepted, ready=0 after
//   queue full; release -> issue in order, max MAX_OUTST unanswered.
//  3 loads issued, flush before responses, 1 new load -> first 3 rsp dropped,
//   exactly one lacc_drsp_valid with 4th data.
//  Half store 0x1001 -> err[0]=1, wstrb=0; stray mem_rsp_valid when idle
//   -> err[1]=1; rst mid-traffic -> all outputs back to reset values at once.

Source files
------------

// File: rtl/lacc_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : lacc_mem_bridge
//  Description : Memory-side stage for the CNN accelerator data port. Queues
//                byte/half/word load-store commands, issues them in order to
//                an SRAM-style request/response bus, and returns lane-aligned
//                load data as a push-only response stream. Supports flush
//                (drop queued work, discard in-flight responses) and sticky
//                error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module lacc_mem_bridge #(
  parameter int REQ_DEPTH = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lacc_flush,
  input  logic        lacc_data_valid,
  output logic        lacc_data_ready,
  input  logic [31:0] lacc_data_addr,
  input  logic        lacc_data_read,
  input  logic [31:0] lacc_data_wdata,
  input  logic [1:0]  lacc_data_size,
  output logic        lacc_drsp_valid,
  output logic [31:0] lacc_drsp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic [1:0]  err,
  output logic        busy
);

  localparam int c_QAW = $clog2(REQ_DEPTH);
  localparam int c_QCW = $clog2(REQ_DEPTH + 1);
  localparam int c_TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int c_OW  = $clog2(MAX_OUTST + 1);

  localparam logic [c_QCW-1:0] c_Q_FULL = c_QCW'(REQ_DEPTH);
  localparam logic [c_OW-1:0]  c_O_MAX  = c_OW'(MAX_OUTST);
  localparam logic [c_TAW-1:0] c_T_LAST = c_TAW'(MAX_OUTST - 1);

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  // Command queue storage
  logic [31:0]      r_q_addr  [REQ_DEPTH];
  logic [31:0]      r_q_wdata [REQ_DEPTH];
  logic [1:0]       r_q_size  [REQ_DEPTH];
  logic             r_q_read  [REQ_DEPTH];
  logic [c_QAW-1:0] r_wr_ptr;
  logic [c_QAW-1:0] r_rd_ptr;
  logic [c_QCW-1:0] r_count;

  // Tag FIFO for issued requests: {read, addr[1:0], size}
  logic [4:0]       r_tag [MAX_OUTST];
  logic [c_TAW-1:0] r_tag_wp;
  logic [c_TAW-1:0] r_tag_rp;

  logic [c_OW-1:0]  r_outst;
  logic [c_OW-1:0]  r_discard;
  logic [c_OW-1:0]  w_outst_nxt;

  logic             r_drsp_valid;
  logic [31:0]      r_drsp_rdata;
  logic [1:0]       r_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_issue;
  logic             w_rsp_take;
  logic             w_rsp_deliver;

  logic [31:0]      w_h_addr;
  logic [31:0]      w_h_wdata;
  logic [1:0]       w_h_size;
  logic             w_h_read;
  logic [1:0]       w_h_off;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata;

  logic [4:0]       w_tag;
  logic             w_tag_read;
  logic [1:0]       w_tag_off;
  logic [1:0]       w_tag_size;
  logic [31:0]      w_shifted;
  logic [31:0]      w_load_data;

  // Misaligned or illegal access: still issued, but flagged and strobe-less
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd3) ||
           ((size == c_SZ_HALF) && off[0]) ||
           ((size == c_SZ_WORD) && (off != 2'b00));
  endfunction

  // Tag FIFO pointer advance with explicit wrap (depth may be 1)
  function automatic logic [c_TAW-1:0] f_tag_inc(input logic [c_TAW-1:0] p);
    if (p == c_T_LAST) return '0;
    return p + 1'b1;
  endfunction

  assign w_full          = (r_count == c_Q_FULL);
  assign w_empty         = (r_count == '0);
  assign lacc_data_ready = !w_full && !lacc_flush;
  assign w_push          = lacc_data_valid && lacc_data_ready;

  assign mem_req_valid   = !w_empty && (r_outst < c_O_MAX);
  assign w_issue         = mem_req_valid && mem_req_ready;

  // Responses with nothing outstanding are strays: flagged, otherwise ignored
  assign w_rsp_take      = mem_rsp_valid && (r_outst != '0);

  assign w_h_addr        = r_q_addr[r_rd_ptr];
  assign w_h_wdata       = r_q_wdata[r_rd_ptr];
  assign w_h_size        = r_q_size[r_rd_ptr];
  assign w_h_read        = r_q_read[r_rd_ptr];
  assign w_h_off         = w_h_addr[1:0];

  assign w_tag           = r_tag[r_tag_rp];
  assign w_tag_read      = w_tag[4];
  assign w_tag_off       = w_tag[3:2];
  assign w_tag_size      = w_tag[1:0];

  assign w_rsp_deliver   = w_rsp_take && (r_discard == '0) && w_tag_read;

  // Queue storage write; contents need no reset, validity lives in r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr]  <= lacc_data_addr;
      r_q_wdata[r_wr_ptr] <= lacc_data_wdata;
      r_q_size[r_wr_ptr]  <= lacc_data_size;
      r_q_read[r_wr_ptr]  <= lacc_data_read;
    end
  end

  // Queue pointers and occupancy; flush empties the queue at the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (lacc_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage write on every issued request
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_tag[r_tag_wp] <= {w_h_read, w_h_off, w_h_size};
    end
  end

  // Tag FIFO pointers; in-flight tags survive flush so responses stay paired
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_wp <= '0;
      r_tag_rp <= '0;
    end else begin
      if (w_issue)    r_tag_wp <= f_tag_inc(r_tag_wp);
      if (w_rsp_take) r_tag_rp <= f_tag_inc(r_tag_rp);
    end
  end

  // Next outstanding count: issue and response in one cycle cancel out
  always_comb begin
    w_outst_nxt = r_outst;
    case ({w_issue, w_rsp_take})
      2'b10:   w_outst_nxt = r_outst + 1'b1;
      2'b01:   w_outst_nxt = r_outst - 1'b1;
      default: w_outst_nxt = r_outst;
    endcase
  end

  // Outstanding and discard counters. At flush every request still unanswered
  // after this edge (including one accepted in the flush cycle) is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (lacc_flush) begin
        r_discard <= w_outst_nxt;
      end else if (w_rsp_take && (r_discard != '0)) begin
        r_discard <= r_discard - 1'b1;
      end
    end
  end

  // Store lane steering from the queue head
  always_comb begin
    w_wstrb = 4'h0;
    w_wdata = w_h_wdata;
    case (w_h_size)
      c_SZ_BYTE: begin
        w_wdata = {4{w_h_wdata[7:0]}};
        w_wstrb = 4'b0001 << w_h_off;
      end
      c_SZ_HALF: begin
        w_wdata = {2{w_h_wdata[15:0]}};
        if (!w_h_off[0]) w_wstrb = 4'b0011 << w_h_off;
      end
      c_SZ_WORD: begin
        if (w_h_off == 2'b00) w_wstrb = 4'hF;
      end
      default: w_wstrb = 4'h0;
    endcase
    if (w_h_read) w_wstrb = 4'h0;
  end

  assign mem_req_addr  = {w_h_addr[31:2], 2'b00};
  assign mem_req_we    = !w_h_read;
  assign mem_req_wstrb = w_wstrb;
  assign mem_req_wdata = w_wdata;

  // Load data alignment: shift the addressed lane down, then zero-extend
  always_comb begin
    w_shifted   = mem_rsp_rdata >> {w_tag_off, 3'b000};
    w_load_data = w_shifted;
    case (w_tag_size)
      c_SZ_BYTE: w_load_data = {24'h0, w_shifted[7:0]};
      c_SZ_HALF: w_load_data = {16'h0, w_shifted[15:0]};
      default:   w_load_data = w_shifted;
    endcase
  end

  // Registered load response; a flush cancels anything landing this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drsp_valid <= 1'b0;
      r_drsp_rdata <= '0;
    end else begin
      r_drsp_valid <= w_rsp_deliver && !lacc_flush;
      if (w_rsp_deliver && !lacc_flush) begin
        r_drsp_rdata <= w_load_data;
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 2'b00;
    end else begin
      if (w_push && f_misaligned(lacc_data_size, lacc_data_addr[1:0])) r_err[0] <= 1'b1;
      if (mem_rsp_valid && (r_outst == '0))                             r_err[1] <= 1'b1;
    end
  end

  assign lacc_drsp_valid = r_drsp_valid;
  assign lacc_drsp_rdata = r_drsp_rdata;
  assign err             = r_err;
  assign busy            = !w_empty || (r_outst != '0) || r_drsp_valid;

endmodule
`default_nettype wire
